// File: rtl/wb_arbiter_pkg.sv
// Writeback arbiter shared types and constants.
// Requester indices, FSM states and slot layout.
package wb_arbiter_pkg;

  localparam int NREQ_DEF = 3;

  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_BR  = 2;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DRAINED
  } wb_state_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [3:0]  tag;
  } wb_slot_t;

  // rd=0 falls off the low end, so x0 never unlocks
  function automatic logic [31:1] rel_onehot(
    input logic [4:0] rd
  );
    logic [31:0] m;
    m = 32'd1 << rd;
    return m[31:1];
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: requester side, drain control
// and register-bank commit port.
interface wb_arbiter_if #(
  parameter int NREQ = 3
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][4:0]  req_rd;
  logic [NREQ-1:0][31:0] req_data;
  logic [NREQ-1:0][3:0]  req_tag;

  logic        drain_req;
  logic        drained;

  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [3:0]  rf_tag;
  logic [31:1] release_mask;
  logic [1:0]  grant_id;
  logic        commit_valid;

  modport master (
    output req_valid,
    output req_rd,
    output req_data,
    output req_tag,
    output drain_req,
    input  req_ready,
    input  drained,
    input  rf_we,
    input  rf_addr,
    input  rf_data,
    input  rf_tag,
    input  release_mask,
    input  grant_id,
    input  commit_valid
  );

  modport slave (
    input  req_valid,
    input  req_rd,
    input  req_data,
    input  req_tag,
    input  drain_req,
    output req_ready,
    output drained,
    output rf_we,
    output rf_addr,
    output rf_data,
    output rf_tag,
    output release_mask,
    output grant_id,
    output commit_valid
  );

endinterface

// File: rtl/wb_arbiter_rr.sv
// Combinational round-robin picker: first set
// request at or after ptr_i, wrapping to 0.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        idx_o    = IW'(j);
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding slot per unit,
// round-robin commit to the register bank.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input logic         clk,
  input logic         reset,
  wb_arbiter_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  wb_state_t       state_q;
  logic [NREQ-1:0] full_q;
  wb_slot_t        slot_q [NREQ];
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   rr_ptr_d;

  logic        commit_q;
  logic        we_q;
  logic [4:0]  addr_q;
  logic [31:0] data_q;
  logic [3:0]  tag_q;
  logic [31:1] mask_q;
  logic [1:0]  gid_q;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gidx;
  logic            gany;
  logic [NREQ-1:0] ready;
  wb_slot_t        win;

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .req_i (full_q),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (gany)
  );

  // a slot granted this cycle may be refilled at the same edge
  assign ready = (state_q == ST_RUN) ?
                 (~full_q | gnt) : '0;

  assign rr_ptr_d = (gidx == IW'(NREQ - 1)) ?
                    '0 : gidx + IW'(1);

  always_comb begin
    win = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) win = slot_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      full_q   <= '0;
      rr_ptr_q <= '0;
      commit_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      tag_q    <= '0;
      mask_q   <= '0;
      gid_q    <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (ready[i] && bus.req_valid[i]) begin
          full_q[i]      <= 1'b1;
          slot_q[i].rd   <= bus.req_rd[i];
          slot_q[i].data <= bus.req_data[i];
          slot_q[i].tag  <= bus.req_tag[i];
        end else if (gnt[i]) begin
          full_q[i] <= 1'b0;
        end
      end

      if (gany) rr_ptr_q <= rr_ptr_d;

      commit_q <= gany;
      we_q     <= gany && (win.rd != 5'd0);
      mask_q   <= gany ? rel_onehot(win.rd) : '0;
      if (gany) begin
        gid_q  <= 2'(gidx);
        addr_q <= win.rd;
        data_q <= win.data;
        tag_q  <= win.tag;
      end

      unique case (state_q)
        ST_RUN: begin
          if (bus.drain_req) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (full_q == '0) state_q <= ST_DRAINED;
        end
        ST_DRAINED: begin
          if (!bus.drain_req) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign bus.req_ready    = ready;
  assign bus.drained      = (state_q == ST_DRAINED);
  assign bus.commit_valid = commit_q;
  assign bus.rf_we        = we_q;
  assign bus.rf_addr      = addr_q;
  assign bus.rf_data      = data_q;
  assign bus.rf_tag       = tag_q;
  assign bus.release_mask = mask_q;
  assign bus.grant_id     = gid_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios then
// random traffic against a cycle-level reference model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if #(.NREQ(3)) bus();

  wb_arbiter #(.NREQ(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  bit          m_full [3];
  logic [4:0]  m_rd   [3];
  logic [31:0] m_data [3];
  logic [3:0]  m_tag  [3];
  int          m_ptr;
  int          m_st;

  logic        e_cv, e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  logic [3:0]  e_tag;
  logic [31:0] e_mask;
  logic [1:0]  e_gid;

  task automatic chk(input string name,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             name, obs, exp);
    end
  endtask

  function automatic int m_grant();
    for (int k = 0; k < 3; k++) begin
      if (m_full[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [2:0] m_ready();
    logic [2:0] r;
    int g;
    g = m_grant();
    for (int i = 0; i < 3; i++)
      r[i] = (m_st == 0) && (!m_full[i] || g == i);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_full[i] = 1'b0;
    m_ptr = 0; m_st = 0;
    e_cv = 0; e_we = 0; e_addr = 0; e_data = 0;
    e_tag = 0; e_mask = 0; e_gid = 0;
  endtask

  task automatic model_edge();
    int g;
    logic [2:0] r;
    bit empty;
    g = m_grant();
    r = m_ready();
    empty = (g < 0);
    if (g >= 0) begin
      e_cv = 1; e_gid = 2'(g);
      e_addr = m_rd[g]; e_data = m_data[g]; e_tag = m_tag[g];
      e_we = (m_rd[g] != 0);
      e_mask = e_we ? (32'd1 << m_rd[g]) : 32'd0;
      m_full[g] = 1'b0;
      m_ptr = (g + 1) % 3;
    end else begin
      e_cv = 0; e_we = 0; e_mask = 0;
    end
    for (int i = 0; i < 3; i++) begin
      if (r[i] && bus.req_valid[i]) begin
        m_full[i] = 1'b1;
        m_rd[i] = bus.req_rd[i];
        m_data[i] = bus.req_data[i];
        m_tag[i] = bus.req_tag[i];
      end
    end
    case (m_st)
      0: if (bus.drain_req) m_st = 1;
      1: if (empty) m_st = 2;
      default: if (!bus.drain_req) m_st = 0;
    endcase
  endtask

  task automatic check_out();
    chk("commit_valid", 64'(bus.commit_valid), 64'(e_cv));
    chk("rf_we", 64'(bus.rf_we), 64'(e_we));
    chk("rf_addr", 64'(bus.rf_addr), 64'(e_addr));
    chk("rf_data", 64'(bus.rf_data), 64'(e_data));
    chk("rf_tag", 64'(bus.rf_tag), 64'(e_tag));
    chk("release_mask", 64'({bus.release_mask, 1'b0}),
        64'(e_mask));
    if (e_cv) chk("grant_id", 64'(bus.grant_id), 64'(e_gid));
    chk("drained", 64'(bus.drained), 64'(m_st == 2));
  endtask

  task automatic cycle();
    #1 chk("req_ready", 64'(bus.req_ready), 64'(m_ready()));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_out();
  endtask

  task automatic set_req(input int i, input logic [4:0] rd,
                         input logic [31:0] d,
                         input logic [3:0] t);
    bus.req_valid[i] = 1'b1;
    bus.req_rd[i] = rd;
    bus.req_data[i] = d;
    bus.req_tag[i] = t;
  endtask

  task automatic idle();
    bus.req_valid = '0;
  endtask

  task automatic do_reset();
    idle();
    bus.drain_req = 1'b0;
    reset = 1'b0;
    #1 model_reset();
    check_out();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_rd = '0;
    bus.req_data = '0;
    bus.req_tag = '0;
    bus.drain_req = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();
    cycle();

    // single ALU writeback
    set_req(WB_ALU, 5'd5, 32'h0000_00AA, 4'd3);
    cycle();
    idle();
    cycle();
    chk("t034_we", 64'(bus.rf_we), 64'd1);
    chk("t034_addr", 64'(bus.rf_addr), 64'd5);
    chk("t034_data", 64'(bus.rf_data), 64'hAA);
    chk("t034_mask", 64'(bus.release_mask), 64'h10);
    chk("t034_gid", 64'(bus.grant_id), 64'd0);
    cycle();

    // three full slots drain in order 0,1,2
    do_reset();
    set_req(WB_ALU, 5'd1, 32'h11, 4'd1);
    set_req(WB_LSU, 5'd2, 32'h22, 4'd2);
    set_req(WB_BR, 5'd3, 32'h33, 4'd3);
    cycle();
    idle();
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t035_gid", 64'(bus.grant_id), 64'(k));
    end
    cycle();

    // rd=0 commit, then pointer sits at 2
    set_req(WB_LSU, 5'd0, 32'h1234, 4'd7);
    cycle();
    idle();
    cycle();
    chk("t036_cv", 64'(bus.commit_valid), 64'd1);
    chk("t036_we", 64'(bus.rf_we), 64'd0);
    set_req(WB_ALU, 5'd9, 32'h99, 4'd9);
    set_req(WB_BR, 5'd10, 32'hA0, 4'd10);
    cycle();
    idle();
    cycle();
    chk("t036_ptr2", 64'(bus.grant_id), 64'd2);
    repeat (2) cycle();

    // ALU streaming against a waiting LSU
    do_reset();
    set_req(WB_ALU, 5'd4, 32'h40, 4'd4);
    set_req(WB_LSU, 5'd6, 32'h60, 4'd6);
    cycle();
    bus.req_valid[WB_LSU] = 1'b0;
    repeat (3) cycle();
    idle();
    repeat (3) cycle();

    // drain with two full slots
    do_reset();
    set_req(WB_ALU, 5'd7, 32'h70, 4'd1);
    set_req(WB_BR, 5'd8, 32'h80, 4'd2);
    cycle();
    idle();
    bus.drain_req = 1'b1;
    repeat (5) cycle();
    chk("t038_drained", 64'(bus.drained), 64'd1);
    bus.drain_req = 1'b0;
    repeat (2) cycle();
    chk("t038_ready", 64'(bus.req_ready), 64'h7);

    // reset with work in flight
    set_req(WB_ALU, 5'd11, 32'hB0, 4'd3);
    set_req(WB_LSU, 5'd12, 32'hC0, 4'd4);
    set_req(WB_BR, 5'd13, 32'hD0, 4'd5);
    cycle();
    idle();
    cycle();
    do_reset();
    chk("t039_ready", 64'(bus.req_ready), 64'h7);
    repeat (3) cycle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        bus.req_valid[i] = 1'($urandom_range(0, 1));
        bus.req_rd[i] = ($urandom_range(0, 3) == 0) ?
                        5'd0 : 5'($urandom);
        bus.req_data[i] = $urandom;
        bus.req_tag[i] = 4'($urandom);
      end
      if ($urandom_range(0, 19) == 0)
        bus.drain_req = ~bus.drain_req;
      cycle();
    end
    idle();
    bus.drain_req = 1'b0;
    repeat (6) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: NREQ, default 3; number of execution-unit writeback requesters (index 0 ALU, 1 LSU, 2 branch/link).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  [NREQ]  requester i presents a writeback.
REQ-005 req_ready  output  [NREQ]  arbiter accepts requester i this cycle.
REQ-006 req_rd  input  [NREQ][5]  destination register.
REQ-007 req_data  input  [NREQ][32]  result value.
REQ-008 req_tag  input  [NREQ][4]  instruction tag carried from operand fetch.
REQ-009 drain_req  input  1  stop accepting new writebacks and empty all slots.
REQ-010 drained  output  1  all slots empty and acceptance stopped.
REQ-011 rf_we  output  1  register-bank write enable.
REQ-012 rf_addr  output  5  register-bank write address.
REQ-013 rf_data  output  32  register-bank write data.
REQ-014 rf_tag  output  4  tag of the committed writeback.
REQ-015 release_mask  output  [31:1]  one-hot unlock of rf_addr for the operand-fetch lock logic.
REQ-016 grant_id  output  2  index of requester committed this cycle; meaningful only when commit_valid=1.
REQ-017 commit_valid  output  1  a slot was committed this cycle (includes rd=0 commits).

Function
REQ-018 One holding slot per requester (valid bit + rd, data, tag); a transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-019 req_ready[i] = state is RUN and (slot i empty or slot i granted in the same cycle).
REQ-020 Arbitration: combinational round-robin among full slots, search starting at pointer rr_ptr, wrapping NREQ-1 -> 0.
REQ-021 On a grant, rr_ptr <= (granted+1) mod NREQ; with no grant, rr_ptr holds.
REQ-022 Granted slot is freed at the edge; if refilled by the same-cycle handshake it holds the new request.
REQ-023 Outputs registered: slot granted in cycle N drives commit_valid, grant_id, rf_addr, rf_data, rf_tag in cycle N+1; latency from accept edge to rf_we high is minimum 2 edges.
REQ-024 rd=0: commit_valid=1, rf_we=0, release_mask=0; slot freed, rr_ptr advances.
REQ-025 rd!=0: rf_we=1, release_mask bit rd=1, all other bits 0.
REQ-026 No commit: commit_valid=0, rf_we=0, release_mask=0; rf_addr/rf_data/rf_tag hold last value.
REQ-027 FSM states RUN, DRAIN, DRAINED. RUN->DRAIN when drain_req=1; DRAIN->DRAINED when all slots empty (entering DRAIN with all empty still takes one cycle in DRAIN); DRAINED->RUN when drain_req=0; DRAIN ignores drain_req until empty.
REQ-028 drained=1 exactly in DRAINED; req_ready=0 in DRAIN and DRAINED; grants continue in DRAIN.
REQ-029 At most one commit per cycle; no slot is ever overwritten while full and not granted.

Reset
REQ-030 On reset low: all slots empty, rr_ptr=0, state RUN, rf_we=0, commit_valid=0, release_mask=0, rf_addr=0, rf_data=0, rf_tag=0, grant_id=0, drained=0.
REQ-031 Reset mid-operation discards pending slots without committing; outputs take reset values immediately (asynchronous).

Structure
REQ-032 Shared package holds NREQ default, requester index constants (WB_ALU, WB_LSU, WB_BR) and the FSM state enum wb_state_t.
REQ-033 Round-robin selection as sub-module rr_arbiter (request vector, pointer in; one-hot grant, index, any-grant out).

Verification
REQ-034 ALU accepts rd=5, data=0x0000_00AA, tag=3 at edge 1 -> edge 2 commit: rf_we=1, rf_addr=5, rf_data=0xAA, release_mask bit5 only, grant_id=0.
REQ-035 All three slots full, rr_ptr=0, no new requests -> commits in order grant_id 0,1,2 on three consecutive cycles, rr_ptr returns to 0.
REQ-036 LSU rd=0 data=0x1234 -> commit_valid=1, rf_we=0, release_mask=0, rr_ptr=2.
REQ-037 ALU held valid continuously with rr_ptr=0, LSU slot full -> ALU granted, then LSU, then ALU; ready stays high while ALU slot granted same cycle.
REQ-038 drain_req=1 with two full slots -> req_ready=0 next cycle, two commits, drained=1; drain_req=0 -> RUN, req_ready=1.
REQ-039 Reset asserted with three full slots -> rf_we=0 immediately, no commits after release, req_ready all 1 in first cycle after reset deasserted.
